// File: rtl/apcpu_pkg.sv
// Shared definitions for the apcpu front end: address width, bubble word and
// the fetch FSM encoding.
package apcpu_pkg;

  localparam int          DEF_ADDR_W   = 24;
  localparam logic [7:0]  NOP_OPCODE   = 8'd255;
  localparam logic [31:0] DEF_NOP_WORD = {24'h000000, NOP_OPCODE};

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {address, instruction} entries. The reported count adds
// the slot reserved for the outstanding memory request, so full means "do not
// issue another fetch".
module fetch_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     rsv_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] used_q;
  logic             do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (used_q == '0);
  assign count_o = used_q + CNT_W'(rsv_i);
  assign full_o  = (count_o == CNT_W'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, do_pop})
        2'b10:   used_q <= used_q + CNT_W'(1);
        2'b01:   used_q <= used_q - CNT_W'(1);
        default: used_q <= used_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: requests words from program memory, buffers them in fetch_fifo
// and hands one word per cycle to the decoder; jumps flush and redirect.
module instruction_fetch
  import apcpu_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_WORD   = DEF_NOP_WORD,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        MemReq,
  output logic [ADDR_W-1:0]           MemAddr,
  input  logic                        MemAck,
  input  logic [31:0]                 MemData,
  input  logic                        StallIn,
  input  logic                        JumpEn,
  input  logic [ADDR_W-1:0]           JumpAddr,
  output logic [31:0]                 InstructionBus,
  output logic                        DataACKOut,
  output logic [ADDR_W-1:0]           PCOut,
  output logic [1:0]                  FetchStateDbg,
  output logic [$clog2(FIFO_DEPTH):0] FifoCountDbg
);

  localparam int ENTRY_W = ADDR_W + 32;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, mem_addr_q, pc_q;
  logic              mem_req_q, ack_q;
  logic [31:0]       instr_q;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop, req_ok;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  fetch_pc_inc;

  // Memory handshake: MemReq/MemAddr stay stable until the cycle MemAck=1,
  // which completes the transfer with MemData valid in that same cycle.
  assign fifo_pop     = !fifo_empty && !StallIn && !JumpEn;
  assign fifo_push    = (state_q == FETCH_REQ) && MemAck && !JumpEn;
  assign req_ok       = !fifo_full || fifo_pop;
  assign fetch_pc_inc = fetch_pc_q + ADDR_W'(1);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (JumpEn),
    .rsv_i   (state_q == FETCH_REQ),
    .data_i  ({fetch_pc_q, MemData}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      instr_q    <= NOP_WORD;
      ack_q      <= 1'b0;
      pc_q       <= '0;
    end else begin
      if (fifo_pop) begin
        instr_q <= fifo_head[31:0];
        pc_q    <= fifo_head[ENTRY_W-1:32];
        ack_q   <= 1'b1;
      end else begin
        instr_q <= NOP_WORD;
        ack_q   <= 1'b0;
      end

      if (JumpEn) begin
        fetch_pc_q <= JumpAddr;
        // A request still waiting for its ack must be completed and dropped.
        if (state_q != FETCH_IDLE && !MemAck) begin
          state_q <= FETCH_DISCARD;
        end else begin
          state_q    <= FETCH_REQ;
          mem_req_q  <= 1'b1;
          mem_addr_q <= JumpAddr;
        end
      end else begin
        case (state_q)
          FETCH_IDLE: begin
            if (req_ok) begin
              state_q    <= FETCH_REQ;
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_pc_q;
            end
          end
          FETCH_REQ: begin
            if (MemAck) begin
              fetch_pc_q <= fetch_pc_inc;
              if (req_ok) begin
                mem_addr_q <= fetch_pc_inc;
              end else begin
                state_q   <= FETCH_IDLE;
                mem_req_q <= 1'b0;
              end
            end
          end
          FETCH_DISCARD: begin
            if (MemAck) begin
              state_q    <= FETCH_REQ;
              mem_addr_q <= fetch_pc_q;
            end
          end
          default: begin
            state_q   <= FETCH_IDLE;
            mem_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MemReq         = mem_req_q;
  assign MemAddr        = mem_addr_q;
  assign InstructionBus = instr_q;
  assign DataACKOut     = ack_q;
  assign PCOut          = pc_q;
  assign FetchStateDbg  = state_q;
  assign FifoCountDbg   = fifo_count;

endmodule
